// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: watches the single-wire bus for a host start
// pulse, then answers with the acknowledge pattern and a 40-bit measurement frame.
module dht11_responder #(
    parameter int CLK_PER_US    = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int ZERO_HIGH_US  = 27,
    parameter int ONE_HIGH_US   = 70
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    inout  wire        transmission_line,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic       corrupt_checksum,
    output logic       busy,
    output logic       frame_done,
    output logic       abort,
    output logic       drive_low
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOST_LOW  = 3'd1,
        RESP_WAIT = 3'd2,
        ACK_LOW   = 3'd3,
        ACK_HIGH  = 3'd4,
        BIT_LOW   = 3'd5,
        BIT_HIGH  = 3'd6,
        END_LOW   = 3'd7
    } state_t;

    // Phase terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [20:0] CNT_MAX       = 21'h1F_FFFF;
    localparam logic [20:0] START_MIN_CYC = 21'(START_MIN_US * CLK_PER_US);
    localparam logic [20:0] RESP_LAST     = 21'(RESP_DELAY_US * CLK_PER_US - 1);
    localparam logic [20:0] ACK_LAST      = 21'(80 * CLK_PER_US - 1);
    localparam logic [20:0] BIT_LOW_LAST  = 21'(50 * CLK_PER_US - 1);
    localparam logic [20:0] ZERO_LAST     = 21'(ZERO_HIGH_US * CLK_PER_US - 1);
    localparam logic [20:0] ONE_LAST      = 21'(ONE_HIGH_US * CLK_PER_US - 1);
    localparam logic [20:0] END_LAST      = 21'(50 * CLK_PER_US - 1);
    localparam logic [20:0] GUARD_CYC     = 21'd4;
    localparam logic [5:0]  LAST_BIT      = 6'd39;

    function automatic logic [7:0] calc_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic       invert
    );
        logic [7:0] sum;
        sum = b0 + b1 + b2 + b3;
        return invert ? ~sum : sum;
    endfunction

    state_t      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic [39:0] frame_q, frame_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        abort_q, abort_d;
    logic        drive_low_q, drive_low_d;
    logic        line_meta_q, line_sync_q;
    logic        collision_s;
    logic [20:0] bit_high_last_s;

    // Our own low is still in the synchronizer for the first cycles of a
    // released phase, so collisions are only believed after a short guard.
    assign collision_s     = (cnt_q >= GUARD_CYC) && !line_sync_q;
    assign bit_high_last_s = frame_q[bit_idx_q] ? ONE_LAST : ZERO_LAST;
    assign drive_low_d     = (state_d == ACK_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);

    assign transmission_line = drive_low_q ? 1'b0 : 1'bz;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign abort             = abort_q;
    assign drive_low         = drive_low_q;

    // Next-state, counter, frame latch and pulse generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 21'd1;
        bit_idx_d    = bit_idx_q;
        frame_d      = frame_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = 21'd0;
            bit_idx_d = 6'd0;
            busy_d    = 1'b0;
            abort_d   = busy_q;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = 21'd0;
                    if (!line_sync_q) begin
                        state_d = HOST_LOW;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HOST_LOW: begin
                    if (!line_sync_q) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 21'd1;
                    end else if (cnt_q >= START_MIN_CYC) begin
                        state_d   = RESP_WAIT;
                        cnt_d     = 21'd0;
                        bit_idx_d = 6'd0;
                        busy_d    = 1'b1;
                        frame_d   = {calc_checksum(hum_int, hum_float, temp_int, temp_float,
                                                   corrupt_checksum),
                                     temp_float, temp_int, hum_float, hum_int};
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 21'd0;
                    end
                end
                RESP_WAIT: begin
                    if (collision_s) begin
                        state_d = IDLE;
                        cnt_d   = 21'd0;
                        busy_d  = 1'b0;
                        abort_d = 1'b1;
                    end else if (cnt_q == RESP_LAST) begin
                        state_d = ACK_LOW;
                        cnt_d   = 21'd0;
                    end else begin
                        state_d = RESP_WAIT;
                    end
                end
                ACK_LOW: begin
                    if (cnt_q == ACK_LAST) begin
                        state_d = ACK_HIGH;
                        cnt_d   = 21'd0;
                    end else begin
                        state_d = ACK_LOW;
                    end
                end
                ACK_HIGH: begin
                    if (collision_s) begin
                        state_d = IDLE;
                        cnt_d   = 21'd0;
                        busy_d  = 1'b0;
                        abort_d = 1'b1;
                    end else if (cnt_q == ACK_LAST) begin
                        state_d   = BIT_LOW;
                        cnt_d     = 21'd0;
                        bit_idx_d = 6'd0;
                    end else begin
                        state_d = ACK_HIGH;
                    end
                end
                BIT_LOW: begin
                    if (cnt_q == BIT_LOW_LAST) begin
                        state_d = BIT_HIGH;
                        cnt_d   = 21'd0;
                    end else begin
                        state_d = BIT_LOW;
                    end
                end
                BIT_HIGH: begin
                    if (collision_s) begin
                        state_d   = IDLE;
                        cnt_d     = 21'd0;
                        bit_idx_d = 6'd0;
                        busy_d    = 1'b0;
                        abort_d   = 1'b1;
                    end else if (cnt_q == bit_high_last_s) begin
                        cnt_d = 21'd0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = END_LOW;
                        end else begin
                            state_d   = BIT_LOW;
                            bit_idx_d = bit_idx_q + 6'd1;
                        end
                    end else begin
                        state_d = BIT_HIGH;
                    end
                end
                END_LOW: begin
                    if (cnt_q == END_LAST) begin
                        state_d      = IDLE;
                        cnt_d        = 21'd0;
                        bit_idx_d    = 6'd0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = END_LOW;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = 21'd0;
                    bit_idx_d = 6'd0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    // State, datapath, registered outputs and the line synchronizer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 21'd0;
            bit_idx_q    <= 6'd0;
            frame_q      <= 40'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            drive_low_q  <= 1'b0;
            line_meta_q  <= 1'b1;
            line_sync_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            frame_q      <= frame_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
            drive_low_q  <= drive_low_d;
            line_meta_q  <= transmission_line;
            line_sync_q  <= line_meta_q;
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: acts as host on the bus, decodes the
// returned frames from drive_low timing and checks them against a scoreboard.
`timescale 1ns/1ps
module tb_dht11_responder;

    localparam int CPU       = 1;
    localparam int START_MIN = 200;
    localparam int RESP      = 30;
    localparam int ZH        = 27;
    localparam int OH        = 70;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       corrupt = 1'b0;
    logic       host_pull = 1'b0;
    logic [7:0] hi = 8'h00, hf = 8'h00, ti = 8'h00, tf = 8'h00;
    logic       busy, frame_done, abort, drive_low;
    wire        line_s;

    int         compared = 0;
    int         mismatched = 0;
    logic [39:0] exp_q[$];
    int         gaps[40];

    pullup pu (line_s);
    assign line_s = host_pull ? 1'b0 : 1'bz;

    always #5 clock = ~clock;

    dht11_responder #(
        .CLK_PER_US(CPU), .START_MIN_US(START_MIN), .RESP_DELAY_US(RESP),
        .ZERO_HIGH_US(ZH), .ONE_HIGH_US(OH)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .transmission_line(line_s),
        .hum_int(hi), .hum_float(hf), .temp_int(ti), .temp_float(tf),
        .corrupt_checksum(corrupt), .busy(busy), .frame_done(frame_done),
        .abort(abort), .drive_low(drive_low)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        hi = a; hf = b; ti = c; tf = d;
    endtask

    // Host start pulse of 'us' microseconds; expected frame queued when requested.
    task automatic host_request(input int us, input logic [39:0] expv, input bit push);
        if (push) exp_q.push_back(expv);
        @(negedge clock);
        host_pull = 1'b1;
        repeat (us * CPU) @(negedge clock);
        host_pull = 1'b0;
    endtask

    // Entered on the first negedge of a released stretch: measures it, then the following low.
    task automatic next_low(output int gap, output int len, output bit ok);
        gap = 0; len = 0; ok = 1'b1;
        while (drive_low !== 1'b1) begin
            gap++;
            if (gap > 400) begin ok = 1'b0; return; end
            @(negedge clock);
        end
        while (drive_low === 1'b1) begin
            len++;
            if (len > 400) begin ok = 1'b0; return; end
            @(negedge clock);
        end
    endtask

    task automatic wait_drive(input string tag);
        int n;
        n = 0;
        while (drive_low !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check({tag, " drive wait"}, 64'(drive_low), 64'(1));
    endtask

    task automatic receive_frame(input string tag, input int skipped);
        int g, l, bad_hi, bad_lo;
        bit ok;
        logic [39:0] got, expv;
        bad_hi = 0; bad_lo = 0; got = 40'd0;
        next_low(g, l, ok);
        if (!ok) begin check({tag, " timeout resp"}, 64'(ok), 64'(1)); return; end
        check({tag, " resp delay"}, 64'((g + skipped >= RESP) && (g + skipped <= RESP + 4)), 64'(1));
        check({tag, " ack low"}, 64'(l), 64'(80 * CPU));
        check({tag, " busy"}, 64'(busy), 64'(1));
        next_low(g, l, ok);
        if (!ok) begin check({tag, " timeout ack"}, 64'(ok), 64'(1)); return; end
        check({tag, " ack high"}, 64'(g), 64'(80 * CPU));
        for (int i = 0; i < 40; i++) begin
            next_low(g, l, ok);
            if (!ok) begin check({tag, " timeout bit"}, 64'(i), 64'(40)); return; end
            gaps[i] = g;
            got[i]  = (g > 48 * CPU);
            if (g != ZH * CPU && g != OH * CPU) bad_hi++;
            if (l != 50 * CPU) bad_lo++;
        end
        check({tag, " frame_done"}, 64'(frame_done), 64'(1));
        check({tag, " busy end"}, 64'(busy), 64'(0));
        check({tag, " bad high times"}, 64'(bad_hi), 64'(0));
        check({tag, " bad low times"}, 64'(bad_lo), 64'(0));
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'(0), 64'(1));
        end else begin
            expv = exp_q.pop_front();
            check({tag, " frame"}, 64'(got), 64'(expv));
        end
        @(negedge clock);
        check({tag, " frame_done pulse"}, 64'(frame_done), 64'(0));
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        logic saw_drive, saw_busy, saw_abort;
        saw_drive = 1'b0; saw_busy = 1'b0; saw_abort = 1'b0;
        repeat (cycles) begin
            @(negedge clock);
            saw_drive |= drive_low;
            saw_busy  |= busy;
            saw_abort |= abort;
        end
        check({tag, " no drive"}, 64'(saw_drive), 64'(0));
        check({tag, " no busy"}, 64'(saw_busy), 64'(0));
        check({tag, " no abort"}, 64'(saw_abort), 64'(0));
    endtask

    initial begin
        int g, l;
        bit ok;
        logic saw_abort, saw_drive;

        repeat (5) @(negedge clock);
        check("reset drive_low", 64'(drive_low), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset frame_done", 64'(frame_done), 64'(0));
        check("reset abort", 64'(abort), 64'(0));
        reset = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clock);

        // Reference frame 0x37/0x00/0x19/0x00, checksum 0x50
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        host_request(300, {8'h50, 8'h00, 8'h19, 8'h00, 8'h37}, 1'b1);
        receive_frame("frameA", 0);
        repeat (20) @(negedge clock);

        // Too-short host low is ignored silently
        host_request(100, 40'd0, 1'b0);
        quiet_window("short", 400);

        // All-ones bytes, checksum 0xFC
        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        host_request(300, {8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b1);
        receive_frame("frameFF", 0);
        check("bit32 high", 64'(gaps[32]), 64'(ZH * CPU));
        check("bit34 high", 64'(gaps[34]), 64'(OH * CPU));
        check("bit39 high", 64'(gaps[39]), 64'(OH * CPU));
        repeat (20) @(negedge clock);

        // Corrupted checksum 0xAF; inputs change once the frame is latched
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        corrupt = 1'b1;
        host_request(300, {8'hAF, 8'h00, 8'h19, 8'h00, 8'h37}, 1'b1);
        repeat (10) @(negedge clock);
        set_bytes(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        corrupt = 1'b0;
        receive_frame("frameBad", 10);
        repeat (20) @(negedge clock);

        // Collision: host pulls low for 5 us in bit 10's high phase
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        host_request(300, 40'd0, 1'b0);
        next_low(g, l, ok);
        next_low(g, l, ok);
        for (int i = 0; i < 10; i++) next_low(g, l, ok);
        check("coll reach bit10", 64'(ok), 64'(1));
        repeat (10) @(negedge clock);
        host_pull = 1'b1;
        saw_abort = 1'b0; saw_drive = 1'b0;
        repeat (5 * CPU) begin
            @(negedge clock);
            saw_abort |= abort;
            saw_drive |= drive_low;
        end
        host_pull = 1'b0;
        check("coll abort", 64'(saw_abort), 64'(1));
        check("coll drive", 64'(saw_drive), 64'(0));
        check("coll busy", 64'(busy), 64'(0));
        quiet_window("after coll", 200);

        // Back-to-back requests
        set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
        host_request(300, {8'h14, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b1);
        receive_frame("b2b1", 0);
        set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
        host_request(300, {8'h0A, 8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
        receive_frame("b2b2", 0);
        repeat (20) @(negedge clock);

        // enable dropped during the acknowledge low
        host_request(300, 40'd0, 1'b0);
        wait_drive("en");
        repeat (5) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check("en drive", 64'(drive_low), 64'(0));
        check("en abort", 64'(abort), 64'(1));
        check("en busy", 64'(busy), 64'(0));
        @(negedge clock);
        check("en abort pulse", 64'(abort), 64'(0));
        enable = 1'b1;
        repeat (20) @(negedge clock);

        // Reset during bit 20's low phase
        host_request(300, 40'd0, 1'b0);
        next_low(g, l, ok);
        next_low(g, l, ok);
        for (int i = 0; i < 19; i++) next_low(g, l, ok);
        wait_drive("rst");
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst drive", 64'(drive_low), 64'(0));
        check("rst abort", 64'(abort), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // Recovery after reset
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        host_request(300, {8'h50, 8'h00, 8'h19, 8'h00, 8'h37}, 1'b1);
        receive_frame("recover", 0);
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
